// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: FSM state encoding,
// bit-period divider helpers and the data width of one character.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // PARITY is only reachable when the even-parity build option is enabled.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int uart_cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producing core and the UART transmitter.
// data is only meaningful in the cycle where valid && ready.
interface uart_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the transmitter: counts 0..DIV-1 while enabled and
// flags the last clock of each period. restart re-phases it at frame start.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  input  logic enable,
  output logic period_end
);

  localparam int CNT_W = uart_cnt_width(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign period_end = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, registered outputs. Defining
// UART_TX_PARITY_EN inserts an even-parity bit between data[7] and the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic      clk,
  input  logic      rstn,
  uart_tx_if.slave  in_if,
  output logic      tx,
  output logic      busy
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
  end

  state_t     state_q;
  logic [7:0] shift_q;
  logic [2:0] idx_q;
  logic       tx_q;
  logic       ready_q;
  logic       busy_q;
`ifdef UART_TX_PARITY_EN
  logic       parity_q;
`endif

  logic accept;
  logic period_end;

  // ready_q is only ever high in IDLE, so accept implies an idle transmitter.
  assign accept = in_if.valid && ready_q;

  uart_bit_timer #(.DIV(DIV)) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .restart    (accept),
    .enable     (busy_q),
    .period_end (period_end)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= START;
            shift_q  <= in_if.data;
            idx_q    <= '0;
            tx_q     <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^in_if.data;
`endif
          end
        end
        START: begin
          if (period_end) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (period_end) begin
            shift_q <= shift_q >> 1;
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              // Present the next bit now so it appears on the pin at the boundary.
              tx_q <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (period_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (period_end) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_if.ready = ready_q;
  assign tx          = tx_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: DUT A runs at DIV=4, DUT B at DIV=2.
// Expected line levels are rebuilt per clock from the byte under test.
`timescale 1ns/1ps
module tb_uart_tx;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_tx_if a_if ();
  uart_tx_if b_if ();
  logic tx_a, busy_a, tx_b, busy_b;

  uart_tx #(.CLK_FREQ(400), .BAUD(100)) dut_a (
    .clk (clk), .rstn (rstn), .in_if (a_if), .tx (tx_a), .busy (busy_a)
  );
  uart_tx #(.CLK_FREQ(200), .BAUD(100)) dut_b (
    .clk (clk), .rstn (rstn), .in_if (b_if), .tx (tx_b), .busy (busy_b)
  );

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic get_tx(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction
  function automatic logic get_ready(input bit sel);
    return sel ? b_if.ready : a_if.ready;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      b_if.valid = v;
      b_if.data  = d;
    end else begin
      a_if.valid = v;
      a_if.data  = d;
    end
  endtask

  // Line level of frame slot j: start, data[0..7], optional parity, stop.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Entered #1 after the accept edge; returns #1 after the edge where ready rises.
  task automatic check_frame(input bit sel, input logic [7:0] b, input string tag,
                             input int glitch_s, input bit chain, input logic [7:0] next_b);
    int div;
    div = sel ? 2 : 4;
    if (chain) drive(sel, 1'b1, next_b);
    else       drive(sel, 1'b0, ~b);
    for (int s = 0; s < NB * div; s++) begin
      if (s == glitch_s) drive(sel, 1'b1, 8'hFF);
      if (glitch_s >= 0 && s == glitch_s + 1) drive(sel, 1'b0, 8'h00);
      chk_eq($sformatf("%s tx s%0d", tag, s), get_tx(sel), exp_bit(b, s / div));
      if (s == 0 || s == NB * div - 1) begin
        chk_eq($sformatf("%s ready s%0d", tag, s), get_ready(sel), 1'b0);
        chk_eq($sformatf("%s busy s%0d", tag, s), get_busy(sel), 1'b1);
      end
      @(posedge clk); #1;
    end
    chk_eq({tag, " ready end"}, get_ready(sel), 1'b1);
    chk_eq({tag, " busy end"}, get_busy(sel), 1'b0);
    chk_eq({tag, " tx end"}, get_tx(sel), 1'b1);
    $display("frame %s: byte %02h, %0d clocks checked", tag, b, NB * div);
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input string tag,
                      input int glitch_s, input bit chain, input logic [7:0] next_b);
    chk_eq({tag, " ready pre"}, get_ready(sel), 1'b1);
    drive(sel, 1'b1, b);
    @(posedge clk); #1;
    check_frame(sel, b, tag, glitch_s, chain, next_b);
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset tx_a", tx_a, 1'b1);
    chk_eq("reset ready_a", a_if.ready, 1'b1);
    chk_eq("reset busy_a", busy_a, 1'b0);
    chk_eq("reset tx_b", tx_b, 1'b1);
    chk_eq("reset ready_b", b_if.ready, 1'b1);
    chk_eq("reset busy_b", busy_b, 1'b0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    send(1'b0, 8'h55, "a55", -1, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back: valid stays high so the next accept lands as ready rises.
    send(1'b0, 8'hA3, "aA3", -1, 1'b1, 8'h0F);
    @(posedge clk); #1;
    check_frame(1'b0, 8'h0F, "a0F", -1, 1'b0, 8'h00);

    send(1'b0, 8'h3C, "a3C glitch", 10, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk_eq($sformatf("no 2nd frame tx c%0d", i), tx_a, 1'b1);
    end
    chk_eq("no 2nd frame ready", a_if.ready, 1'b1);

    // Abort a frame inside data bit 3 with an asynchronous reset.
    chk_eq("aC6 ready pre", a_if.ready, 1'b1);
    drive(1'b0, 1'b1, 8'hC6);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00);
    for (int s = 0; s <= 18; s++) begin
      chk_eq($sformatf("aC6 tx s%0d", s), tx_a, exp_bit(8'hC6, s / 4));
      if (s < 18) begin
        @(posedge clk); #1;
      end
    end
    #2 rstn = 1'b0;
    drive(1'b0, 1'b1, 8'h81);
    #1;
    chk_eq("async rst tx", tx_a, 1'b1);
    chk_eq("async rst ready", a_if.ready, 1'b1);
    chk_eq("async rst busy", busy_a, 1'b0);
    @(posedge clk); #1;
    chk_eq("rst valid ignored tx", tx_a, 1'b1);
    chk_eq("rst valid ignored busy", busy_a, 1'b0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check_frame(1'b0, 8'h81, "a81 post-reset", -1, 1'b0, 8'h00);

    send(1'b1, 8'h00, "b00 div2", -1, 1'b0, 8'h00);
    send(1'b0, 8'h07, "a07", -1, 1'b0, 8'h00);
    send(1'b0, 8'h03, "a03", -1, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
